mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64: request address width.
REQ-002 Parameter DATA_W, default 64: data width, both requesters.
REQ-003 Parameter STARVE_MAX, default 4: consecutive MEM grants allowed while IF is waiting (guard build only).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 if_req / if_addr  in  1 / ADDR_W  fetch request, read-only; held until if_gnt.
REQ-007 mem_req / mem_we / mem_addr / mem_wdata  in  1 / 1 / ADDR_W / DATA_W  MEM-stage request, held until mem_gnt; mem_req = MemRead|MemWrite, mem_we = MemWrite.
REQ-008 if_gnt, mem_gnt  out  1 each  one-cycle grant pulse; request fields captured on this edge.
REQ-009 if_done, mem_done  out  1 each  one-cycle completion pulse.
REQ-010 rdata  out  DATA_W  read data, valid with a done pulse of a read, held until the next read's done.
REQ-011 port_req / port_we / port_addr / port_wdata  out  1 / 1 / ADDR_W / DATA_W  registered request to the single memory port.
REQ-012 port_ready / port_rvalid / port_rdata  in  1 / 1 / DATA_W  port accept, read response, read data.

Function
REQ-013 FSM states: IDLE, REQ, WAIT; exactly one transaction outstanding.
REQ-014 IDLE: with any request present, the arbiter asserts exactly one gnt combinationally, captures owner, we, addr, wdata, and moves to REQ; with no request it stays in IDLE.
REQ-015 Priority: MEM over IF, subject to REQ-026.
REQ-016 REQ: port_req=1, port fields = captured values; stays in REQ until port_ready=1.
REQ-017 Accept of a write: move to IDLE; owner done pulses the next cycle.
REQ-018 Accept of a read: move to WAIT; port_req=0 the following cycle.
REQ-019 WAIT: on port_rvalid, rdata <= port_rdata, owner done pulses the next cycle, move to IDLE.
REQ-020 Minimum latency, gnt cycle = 0: write done at cycle 2; read done at cycle 3 (ready in 1, rvalid in 2).
REQ-021 port_rvalid outside WAIT is ignored; rdata is unchanged.
REQ-022 A request arriving during REQ/WAIT is not granted until the cycle after return to IDLE; the requester holds it.
REQ-023 Simultaneous if_req and mem_req in IDLE: only one gnt asserts; the loser retains its request.
REQ-024 A request withdrawn before gnt is never granted and has no side effects.

Reset
REQ-025 On rst_n low, at any time including mid-transaction: state=IDLE; port_req, port_we, gnt, and done outputs are 0; port_addr, port_wdata, and rdata are 0; starve counter is 0; any in-flight response is discarded.

Configuration
REQ-026 With MEM_ARB_STARVE_GUARD_EN defined: a counter increments on each mem_gnt issued while if_req=1 and clears on if_gnt. When the counter equals STARVE_MAX and if_req=1, the next IDLE grant goes to IF.
REQ-027 Without MEM_ARB_STARVE_GUARD_EN: strict MEM priority applies, no counter logic is present, and STARVE_MAX is unused.

Structure
REQ-028 Package mem_arb_pkg holds the FSM state encoding, the owner ID constants (OWN_IF, OWN_MEM), and the default width constants.
REQ-029 One sub-module, mem_arb_starve_ctr, holds the guard counter and is instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-030 IF read 0x100, port_ready=1 immediate, port_rdata=0xDEAD returned the next cycle -> if_gnt at cycle 0, port_req at cycle 1, if_done with rdata=0xDEAD at cycle 3.
REQ-031 MEM write 0x200/0x55 with port_ready delayed 3 cycles -> port_req high for cycles 1-4 with stable fields, mem_done at cycle 5, rdata unchanged.
REQ-032 if_req and mem_req both asserted in one IDLE cycle -> mem_gnt only; if_gnt in the first IDLE cycle after mem_done.
REQ-033 Guard on, STARVE_MAX=4, mem_req and if_req held continuously -> grant sequence MEM, MEM, MEM, MEM, IF, MEM...; guard off -> IF never granted.
REQ-034 rst_n low while in WAIT, port_rvalid asserted after reset release -> no done pulse, rdata=0, state IDLE.
REQ-035 Spurious port_rvalid in IDLE with rdata=0x1 -> rdata and done outputs unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port memory arbiter: FSM state
// encoding, transaction owner IDs and default widths.
package mem_arb_pkg;

   localparam int DEF_ADDR_W     = 64;
   localparam int DEF_DATA_W     = 64;
   localparam int DEF_STARVE_MAX = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts MEM grants issued while IF is waiting; once STARVE_MAX is reached
// the next IDLE grant is forced to IF. Cleared by any IF grant.
module mem_arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic if_gnt,
   input  logic mem_gnt,
   output logic force_if
);

   localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] cnt;

   // saturates at CNT_MAX so a waiting IF cannot be skipped by wraparound
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (if_gnt) begin
         cnt <= '0;
      end else if (mem_gnt && if_req && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign force_if = if_req && (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and MEM-stage requests onto one memory port,
// one transaction outstanding. Optional IF starvation guard: MEM_ARB_STARVE_GUARD_EN.
//
// state   | meaning
// IDLE    | no transaction; grant the winning request combinationally
// REQ     | port_req high with captured fields until port_ready
// WAIT    | read accepted, waiting for port_rvalid
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              if_gnt,
   output logic              mem_gnt,
   output logic              if_done,
   output logic              mem_done,
   output logic [DATA_W-1:0] rdata,
   output logic              port_req,
   output logic              port_we,
   output logic [ADDR_W-1:0] port_addr,
   output logic [DATA_W-1:0] port_wdata,
   input  logic              port_ready,
   input  logic              port_rvalid,
   input  logic [DATA_W-1:0] port_rdata
);

   arb_state_t state, state_nxt;
   owner_t     owner;
   logic       done_q;
   logic       force_if;
   logic       grant_if, grant_mem;

   if (STARVE_MAX < 1) begin : g_bad_starve_max
      $error("STARVE_MAX must be at least 1");
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   mem_arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_gnt   (grant_if),
      .mem_gnt  (grant_mem),
      .force_if (force_if)
   );
`else
   assign force_if = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // grants are gated by rst_n so none can leak out while reset is held
   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rst_n) begin
               if (mem_req && !force_if) begin
                  grant_mem = 1'b1;
               end else if (if_req) begin
                  grant_if = 1'b1;
               end
               if (grant_if || grant_mem) begin
                  state_nxt = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (port_ready) begin
               state_nxt = port_we ? ST_IDLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (port_rvalid) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign if_gnt  = grant_if;
   assign mem_gnt = grant_mem;

   // port fields stay at the last granted values; owner steers the done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         port_req   <= 1'b0;
         port_we    <= 1'b0;
         port_addr  <= '0;
         port_wdata <= '0;
         owner      <= OWN_IF;
         done_q     <= 1'b0;
         rdata      <= '0;
      end else begin
         done_q <= 1'b0;
         if (grant_if || grant_mem) begin
            port_req   <= 1'b1;
            owner      <= grant_mem ? OWN_MEM : OWN_IF;
            port_we    <= grant_mem && mem_we;
            port_addr  <= grant_mem ? mem_addr : if_addr;
            port_wdata <= grant_mem ? mem_wdata : '0;
         end
         if ((state == ST_REQ) && port_ready) begin
            port_req <= 1'b0;
            done_q   <= port_we;
         end
         if ((state == ST_WAIT) && port_rvalid) begin
            rdata  <= port_rdata;
            done_q <= 1'b1;
         end
      end
   end

   assign if_done  = done_q && (owner == OWN_IF);
   assign mem_done = done_q && (owner == OWN_MEM);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

   localparam int AW   = 64;
   localparam int DW   = 64;
   localparam int SMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic [AW-1:0] mem_addr = '0;
   logic [DW-1:0] mem_wdata = '0;
   logic          port_ready = 1'b0;
   logic          port_rvalid = 1'b0;
   logic [DW-1:0] port_rdata = '0;
   logic          if_gnt, mem_gnt, if_done, mem_done;
   logic [DW-1:0] rdata;
   logic          port_req, port_we;
   logic [AW-1:0] port_addr;
   logic [DW-1:0] port_wdata;

   mem_port_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .if_gnt      (if_gnt),
      .mem_gnt     (mem_gnt),
      .if_done     (if_done),
      .mem_done    (mem_done),
      .rdata       (rdata),
      .port_req    (port_req),
      .port_we     (port_we),
      .port_addr   (port_addr),
      .port_wdata  (port_wdata),
      .port_ready  (port_ready),
      .port_rvalid (port_rvalid),
      .port_rdata  (port_rdata)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // transaction model: phase 0 = port free, 1 = request on port, 2 = awaiting read data
   int            m_phase = 0;
   bit            m_own_mem = 1'b0;
   bit            m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_rdata = '0;
   bit            m_done_if = 1'b0;
   bit            m_done_mem = 1'b0;
   int            m_cnt = 0;
   bit            run = 1'b0;

   function automatic bit pick_if();
      return rst_n && (m_phase == 0) && if_req && (!mem_req || (GUARD && (m_cnt >= SMAX)));
   endfunction

   function automatic bit pick_mem();
      return rst_n && (m_phase == 0) && mem_req && !pick_if();
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit gi, gm, fin;
      if (!rst_n) begin
         m_phase = 0; m_own_mem = 0; m_we = 0; m_addr = '0; m_wdata = '0;
         m_rdata = '0; m_done_if = 0; m_done_mem = 0; m_cnt = 0;
      end else begin
         gi = pick_if();
         gm = pick_mem();
         fin = 1'b0;
         m_done_if = 0;
         m_done_mem = 0;
         if (gi) m_cnt = 0;
         else if (gm && if_req && (m_cnt < SMAX)) m_cnt++;
         case (m_phase)
            0: if (gi || gm) begin
               m_phase   = 1;
               m_own_mem = gm;
               m_we      = gm && mem_we;
               m_addr    = gm ? mem_addr : if_addr;
               m_wdata   = gm ? mem_wdata : '0;
            end
            1: if (port_ready) begin
               if (m_we) begin m_phase = 0; fin = 1'b1; end
               else m_phase = 2;
            end
            default: if (port_rvalid) begin
               m_rdata = port_rdata;
               m_phase = 0;
               fin = 1'b1;
            end
         endcase
         if (fin) begin
            if (m_own_mem) m_done_mem = 1;
            else m_done_if = 1;
         end
      end
   end

   logic lg_if = 1'b0, lg_mem = 1'b0;

   always @(negedge clk) begin
      lg_if  = if_gnt;
      lg_mem = mem_gnt;
      if (run) begin
         check("m if_gnt", if_gnt, pick_if());
         check("m mem_gnt", mem_gnt, pick_mem());
         check("m if_done", if_done, m_done_if);
         check("m mem_done", mem_done, m_done_mem);
         check("m rdata", rdata, m_rdata);
         check("m port_req", port_req, m_phase == 1);
         check("m port_we", port_we, m_we);
         check("m port_addr", port_addr, m_addr);
         check("m port_wdata", port_wdata, m_wdata);
      end
   end

   bit hold_if = 1'b0, hold_mem = 1'b0;

   // requesters drop their request once granted unless told to hold it
   task automatic next();
      @(posedge clk);
      #1;
      if (lg_if && !hold_if) if_req = 1'b0;
      if (lg_mem && !hold_mem) mem_req = 1'b0;
   endtask

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   task automatic drain(input logic [DW-1:0] rd);
      port_ready = 1'b1;
      port_rvalid = 1'b1;
      port_rdata = rd;
      for (int c = 0; c < 20; c++) begin
         if ((m_phase == 0) && !if_req && !mem_req) break;
         next();
      end
      look();
      check("drain port_req", port_req, 0);
      port_ready = 1'b0;
      port_rvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      byte seq [6];
      int  got;
      byte e;

      #2 rst_n = 1'b0;
      run = 1'b1;
      mem_req = 1'b1;
      look();
      check("rst mem_gnt", mem_gnt, 0);
      check("rst port_req", port_req, 0);
      check("rst rdata", rdata, 0);
      mem_req = 1'b0;
      next();
      rst_n = 1'b1;

      // IF read, immediate accept, data next cycle
      if_req = 1'b1; if_addr = 64'h100; port_ready = 1'b1;
      look();
      check("A c0 if_gnt", if_gnt, 1);
      check("A c0 mem_gnt", mem_gnt, 0);
      next();
      look();
      check("A c1 port_req", port_req, 1);
      check("A c1 port_addr", port_addr, 64'h100);
      next();
      port_rvalid = 1'b1; port_rdata = 64'hDEAD;
      look();
      check("A c2 port_req", port_req, 0);
      check("A c2 if_done", if_done, 0);
      next();
      port_rvalid = 1'b0; port_ready = 1'b0;
      look();
      check("A c3 if_done", if_done, 1);
      check("A c3 rdata", rdata, 64'hDEAD);
      next();
      look();
      check("A c4 if_done", if_done, 0);
      next();

      // MEM write with ready delayed; IF request withdrawn while busy
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h200; mem_wdata = 64'h55;
      look();
      check("B c0 mem_gnt", mem_gnt, 1);
      next();
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) begin if_req = 1'b1; if_addr = 64'h999; end
         if (c == 3) if_req = 1'b0;
         if (c == 4) port_ready = 1'b1;
         look();
         check($sformatf("B c%0d port_req", c), port_req, 1);
         check($sformatf("B c%0d port_addr", c), port_addr, 64'h200);
         check($sformatf("B c%0d port_wdata", c), port_wdata, 64'h55);
         check($sformatf("B c%0d port_we", c), port_we, 1);
         check($sformatf("B c%0d mem_done", c), mem_done, 0);
         next();
      end
      port_ready = 1'b0; mem_we = 1'b0;
      look();
      check("B c5 mem_done", mem_done, 1);
      check("B c5 port_req", port_req, 0);
      check("B c5 rdata", rdata, 64'hDEAD);
      check("B c5 if_gnt", if_gnt, 0);
      next();

      // simultaneous requests: MEM read wins, IF follows on return to IDLE
      if_req = 1'b1; if_addr = 64'h300;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h400; port_ready = 1'b1;
      look();
      check("C c0 mem_gnt", mem_gnt, 1);
      check("C c0 if_gnt", if_gnt, 0);
      next();
      look();
      check("C c1 if_gnt", if_gnt, 0);
      check("C c1 port_addr", port_addr, 64'h400);
      next();
      port_rvalid = 1'b1; port_rdata = 64'h1234;
      look();
      check("C c2 if_gnt", if_gnt, 0);
      next();
      port_rvalid = 1'b0;
      look();
      check("C c3 mem_done", mem_done, 1);
      check("C c3 rdata", rdata, 64'h1234);
      check("C c3 if_gnt", if_gnt, 1);
      next();
      look();
      check("C c4 port_addr", port_addr, 64'h300);
      check("C c4 port_we", port_we, 0);
      next();
      port_rvalid = 1'b1; port_rdata = 64'hABCD;
      look();
      next();
      port_rvalid = 1'b0;
      look();
      check("C c6 if_done", if_done, 1);
      check("C c6 rdata", rdata, 64'hABCD);
      next();

      // both requesters held continuously: grant order
      hold_if = 1'b1; hold_mem = 1'b1;
      if_req = 1'b1; if_addr = 64'h380;
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h600; mem_wdata = 64'h66;
      port_ready = 1'b1; port_rvalid = 1'b1; port_rdata = 64'h4242;
      got = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         look();
         if (if_gnt && got < 6) begin seq[got] = "I"; got++; end
         if (mem_gnt && got < 6) begin seq[got] = "M"; got++; end
         next();
      end
      check("D grant count", got, 6);
      for (int i = 0; i < 6; i++) begin
         e = (GUARD && (i == SMAX)) ? "I" : "M";
         if (i < got) check($sformatf("D grant %0d", i), seq[i], e);
      end
      hold_if = 1'b0; hold_mem = 1'b0;
      if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      drain(64'h4242);
      next();

      // reset while waiting for read data; late response must be dropped
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h500; port_ready = 1'b1;
      look();
      check("E c0 mem_gnt", mem_gnt, 1);
      next();
      look();
      next();
      rst_n = 1'b0;
      look();
      check("E rst port_req", port_req, 0);
      check("E rst rdata", rdata, 0);
      check("E rst port_addr", port_addr, 0);
      check("E rst mem_done", mem_done, 0);
      next();
      rst_n = 1'b1; port_rvalid = 1'b1; port_rdata = 64'hBEEF;
      for (int c = 0; c < 2; c++) begin
         look();
         check($sformatf("E post%0d mem_done", c), mem_done, 0);
         check($sformatf("E post%0d rdata", c), rdata, 0);
         next();
      end
      port_rvalid = 1'b0;
      if_req = 1'b1; if_addr = 64'h700;
      look();
      check("E idle if_gnt", if_gnt, 1);
      next();
      drain(64'h1);
      check("E rdata one", rdata, 64'h1);
      next();

      // spurious rvalid in IDLE
      port_rvalid = 1'b1; port_rdata = 64'hFFFF; port_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         look();
         check($sformatf("F c%0d rdata", c), rdata, 64'h1);
         check($sformatf("F c%0d if_done", c), if_done, 0);
         check($sformatf("F c%0d mem_done", c), mem_done, 0);
         next();
      end
      port_rvalid = 1'b0;
      look();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
